// File: rtl/activity_trigger_gen.sv
// activity_trigger_gen: per-channel beat decimator driving holdoff-limited one-cycle trigger pulses
// Stall counters and stall_flag are built only when ACTIVITY_STALL_DETECT_EN is defined.
module activity_trigger_gen #(
  parameter int NUM_CH         = 4,
  parameter int DIV_WIDTH      = 8,
  parameter int HOLDOFF_CYCLES = 1023,
  parameter int STALL_LIMIT    = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH-1:0]    ch_ready,
  input  logic [DIV_WIDTH-1:0] beat_div,
  input  logic                 clear,
  output logic [NUM_CH-1:0]    trigger_out,
  output logic [NUM_CH-1:0]    stall_flag
);
  localparam int HW = HOLDOFF_CYCLES > 0 ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
  logic [DIV_WIDTH-1:0] div_last;
  // A divisor of 0 behaves as 1, so the last count value is 0 in both cases
  assign div_last = (beat_div == '0) ? '0 : beat_div - DIV_WIDTH'(1);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [HW-1:0]        hold;
    logic                 pend, trig, beat, done;
    assign beat = ch_valid[g] & ch_ready[g];
    assign done = beat & (cnt >= div_last);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        hold  <= '0;
        pend  <= 1'b0;
        trig  <= 1'b0;
      end else if (clear) begin
        state <= IDLE;
        cnt   <= '0;
        hold  <= '0;
        pend  <= 1'b0;
        trig  <= 1'b0;
      end else begin
        if (beat) cnt <= done ? '0 : cnt + DIV_WIDTH'(1);
        case (state)
          IDLE: begin
            trig <= done | pend;
            pend <= 1'b0;
            if (done | pend) state <= FIRE;
          end
          FIRE: begin
            trig  <= 1'b0;
            pend  <= done;
            hold  <= HW'(HOLDOFF_CYCLES);
            state <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
          end
          HOLD: begin
            if (hold == '0) begin
              trig  <= done | pend;
              pend  <= 1'b0;
              state <= (done | pend) ? FIRE : IDLE;
            end else begin
              hold <= hold - HW'(1);
              pend <= pend | done;
            end
          end
          default: begin
            trig  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
    assign trigger_out[g] = trig;
`ifdef ACTIVITY_STALL_DETECT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] scnt;
    logic          sflag, stall;
    assign stall = ch_valid[g] & ~ch_ready[g];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scnt  <= '0;
        sflag <= 1'b0;
      end else if (clear) begin
        scnt  <= '0;
        sflag <= 1'b0;
      end else begin
        scnt  <= !stall ? '0 : (scnt == SW'(STALL_LIMIT)) ? scnt : scnt + SW'(1);
        sflag <= stall & (scnt >= SW'(STALL_LIMIT - 1));
      end
    end
    assign stall_flag[g] = sflag;
`else
    assign stall_flag[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_activity_trigger_gen.sv
// tb_activity_trigger_gen: two DUTs (holdoff 10 and 0) checked against a timestamp-based reference model
module tb_activity_trigger_gen;
  localparam int HA = 10, HB = 0, SL = 20;
  logic clk = 0, rst_n = 0, clr = 0;
  logic [3:0] v = 0, r = 0;
  logic [7:0] div = 1;
  logic [3:0] trig_a, trig_b, stall_a, stall_b;
  int tests = 0, fails = 0, cyc = 0;
  int cnt_m [4], run_m [4], lastf_m [2][4];
  bit pend_m [2][4];
  logic [3:0] exp_t [2];
  logic [3:0] exp_s;

  activity_trigger_gen #(.NUM_CH(4), .DIV_WIDTH(8), .HOLDOFF_CYCLES(HA), .STALL_LIMIT(SL)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_valid(v), .ch_ready(r), .beat_div(div), .clear(clr),
    .trigger_out(trig_a), .stall_flag(stall_a));
  activity_trigger_gen #(.NUM_CH(4), .DIV_WIDTH(8), .HOLDOFF_CYCLES(HB), .STALL_LIMIT(SL)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_valid(v), .ch_ready(r), .beat_div(div), .clear(clr),
    .trigger_out(trig_b), .stall_flag(stall_b));

  always #5 clk = ~clk;

  // Reference: a completed division fires one cycle later once at least holdoff+2 cycles
  // have passed since the previous pulse; completions in between merge into one pending bit.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 4; i++) begin
        if (!rst_n || clr) begin
          cnt_m[i] = 0; run_m[i] = 0; exp_s[i] = 0;
          for (int k = 0; k < 2; k++) begin
            pend_m[k][i] = 0; lastf_m[k][i] = -1000; exp_t[k][i] = 0;
          end
        end else begin
          automatic bit beat = v[i] & r[i];
          automatic bit st = v[i] & ~r[i];
          automatic int eff = (div == 0) ? 1 : int'(div);
          automatic bit done = beat && (cnt_m[i] + 1 >= eff);
          if (beat) cnt_m[i] = done ? 0 : cnt_m[i] + 1;
          for (int k = 0; k < 2; k++) begin
            automatic int h = (k == 0) ? HA : HB;
            automatic bit fire;
            pend_m[k][i] = pend_m[k][i] | done;
            fire = pend_m[k][i] && (cyc - lastf_m[k][i] >= h + 1);
            if (fire) begin
              lastf_m[k][i] = cyc + 1;
              pend_m[k][i] = 0;
            end
            exp_t[k][i] = fire;
          end
          run_m[i] = st ? run_m[i] + 1 : 0;
`ifdef ACTIVITY_STALL_DETECT_EN
          exp_s[i] = st && run_m[i] >= SL;
`else
          exp_s[i] = 0;
`endif
        end
      end
      if (rst_n) cyc++;
    end
  end

  task automatic quiesce();
    v = 0; r = 0; clr = 1;
    @(negedge clk);
    clr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; v = 0; r = 0; div = 1; clr = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      tests++;
      if (trig_a !== 4'h0 || trig_b !== 4'h0 || stall_a !== 4'h0 || stall_b !== 4'h0) begin
        fails++;
        $display("FAIL reset_hold j=%0d trig_a=%b trig_b=%b stall_a=%b stall_b=%b expected all 0", j, trig_a, trig_b, stall_a, stall_b);
      end
    end
    rst_n = 1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      tests++;
      if (trig_a !== 4'h0 || trig_b !== 4'h0 || stall_a !== 4'h0 || stall_b !== 4'h0) begin
        fails++;
        $display("FAIL reset_idle j=%0d trig_a=%b trig_b=%b stall_a=%b stall_b=%b expected all 0", j, trig_a, trig_b, stall_a, stall_b);
      end
    end
  endtask

  task automatic test_decimation();
    int pulses = 0;
    quiesce();
    div = 4;
    for (int j = 0; j < 18; j++) begin
      v = (j < 16) ? 4'b0001 : 4'b0000; r = v;
      @(negedge clk);
      pulses += int'(trig_b[0]);
      tests++;
      if (trig_b !== {3'b000, (j < 16 && j % 4 == 3)} || trig_a !== exp_t[0]) begin
        fails++;
        $display("FAIL decimation j=%0d trig_b=%b want %b trig_a=%b want %b", j, trig_b, {3'b000, (j < 16 && j % 4 == 3)}, trig_a, exp_t[0]);
      end
    end
    tests++;
    if (pulses != 4) begin
      fails++;
      $display("FAIL decimation_count got %0d want 4", pulses);
    end
  endtask

  task automatic test_holdoff();
    int pulses = 0;
    quiesce();
    div = 1;
    for (int j = 0; j < 45; j++) begin
      v = (j < 30) ? 4'b0010 : 4'b0000; r = v;
      @(negedge clk);
      if (j < 30) pulses += int'(trig_a[1]);
      tests++;
      if ((j < 30 && trig_a[1] !== (j % 12 == 0)) || trig_a !== exp_t[0] || trig_b !== exp_t[1]) begin
        fails++;
        $display("FAIL holdoff j=%0d trig_a=%b model %b trig_b=%b model %b", j, trig_a, exp_t[0], trig_b, exp_t[1]);
      end
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL holdoff_count got %0d want 3", pulses);
    end
  endtask

  task automatic test_divisor_edge();
    quiesce();
    div = 0;
    for (int j = 0; j < 8; j++) begin
      v = (j % 2 == 0) ? 4'b1000 : 4'b0000; r = v;
      @(negedge clk);
      tests++;
      if (trig_b[3] !== (j % 2 == 0) || trig_a !== exp_t[0] || trig_b !== exp_t[1]) begin
        fails++;
        $display("FAIL div_zero j=%0d trig_a=%b model %b trig_b=%b model %b", j, trig_a, exp_t[0], trig_b, exp_t[1]);
      end
    end
    quiesce();
    div = 8;
    v = 4'b1000; r = 4'b1000;
    repeat (5) @(negedge clk);
    v = 0; r = 0; div = 2;
    @(negedge clk);
    tests++;
    if (trig_a !== 4'h0 || trig_b !== 4'h0) begin
      fails++;
      $display("FAIL div_count5 trig_a=%b trig_b=%b want 0000", trig_a, trig_b);
    end
    v = 4'b1000; r = 4'b1000;
    @(negedge clk);
    v = 0; r = 0;
    tests++;
    if (trig_a !== 4'b1000 || trig_b !== 4'b1000) begin
      fails++;
      $display("FAIL div_lowered trig_a=%b trig_b=%b want 1000", trig_a, trig_b);
    end
  endtask

  task automatic test_stall();
    quiesce();
    div = 200;
    for (int j = 0; j < 28; j++) begin
      automatic logic want;
      v = (j < 26) ? 4'b0100 : 4'b0000;
      r = (j == 25) ? 4'b0100 : 4'b0000;
`ifdef ACTIVITY_STALL_DETECT_EN
      want = (j >= SL - 1 && j < 25);
`else
      want = 1'b0;
`endif
      @(negedge clk);
      tests++;
      if (stall_a !== {1'b0, want, 2'b00} || stall_b !== exp_s || stall_a !== exp_s) begin
        fails++;
        $display("FAIL stall j=%0d stall_a=%b stall_b=%b want %b", j, stall_a, stall_b, {1'b0, want, 2'b00});
      end
    end
  endtask

  task automatic test_clear();
    quiesce();
    div = 1;
    v = 4'b0010; r = 4'b0010;
    repeat (5) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0; v = 0; r = 0;
    tests++;
    if (trig_a !== 4'h0 || trig_b !== 4'h0 || stall_a !== 4'h0) begin
      fails++;
      $display("FAIL clear_now trig_a=%b trig_b=%b stall_a=%b want 0", trig_a, trig_b, stall_a);
    end
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      tests++;
      if (trig_a !== 4'h0 || trig_b !== 4'h0) begin
        fails++;
        $display("FAIL clear_quiet j=%0d trig_a=%b trig_b=%b want 0000", j, trig_a, trig_b);
      end
    end
    div = 3;
    for (int j = 0; j < 4; j++) begin
      v = (j < 3) ? 4'b0010 : 4'b0000; r = v;
      @(negedge clk);
      tests++;
      if (trig_a !== {2'b00, (j == 2), 1'b0}) begin
        fails++;
        $display("FAIL clear_rebeat j=%0d trig_a=%b want %b", j, trig_a, {2'b00, (j == 2), 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    div = 1;
    v = 4'b0010; r = 4'b0010;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if (trig_a !== 4'h0 || trig_b !== 4'h0 || stall_a !== 4'h0 || stall_b !== 4'h0) begin
      fails++;
      $display("FAIL reset_async trig_a=%b trig_b=%b stall_a=%b stall_b=%b want 0", trig_a, trig_b, stall_a, stall_b);
    end
    @(negedge clk);
    rst_n = 1; v = 0; r = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      tests++;
      if (trig_a !== 4'h0 || trig_b !== 4'h0) begin
        fails++;
        $display("FAIL reset_quiet j=%0d trig_a=%b trig_b=%b want 0000", j, trig_a, trig_b);
      end
    end
    div = 3;
    for (int j = 0; j < 4; j++) begin
      v = (j < 3) ? 4'b0010 : 4'b0000; r = v;
      @(negedge clk);
      tests++;
      if (trig_a !== {2'b00, (j == 2), 1'b0}) begin
        fails++;
        $display("FAIL reset_rebeat j=%0d trig_a=%b want %b", j, trig_a, {2'b00, (j == 2), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    quiesce();
    for (int j = 0; j < 800; j++) begin
      v = (j < 400) ? 4'($urandom) : 4'($urandom) | 4'($urandom);
      r = (j < 400) ? 4'($urandom) : 4'($urandom) & 4'($urandom) & 4'($urandom);
      div = 8'($urandom_range(0, 4));
      clr = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      tests++;
      if (trig_a !== exp_t[0] || trig_b !== exp_t[1] || stall_a !== exp_s || stall_b !== exp_s) begin
        fails++;
        $display("FAIL random j=%0d trig_a=%b model %b trig_b=%b model %b stall_a=%b stall_b=%b model %b", j, trig_a, exp_t[0], trig_b, exp_t[1], stall_a, stall_b, exp_s);
      end
    end
    clr = 0; v = 0; r = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_decimation();
    test_holdoff();
    test_divisor_edge();
    test_stall();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/activity_trigger_gen.md
# activity_trigger_gen

Per-channel activity detector feeding the `trigger` inputs of the LED blinker stage.
- Watches valid/ready handshakes on up to NUM_CH stream interfaces and decimates accepted beats by a programmable divisor.
- Emits one-cycle trigger pulses rate-limited by a holdoff window.
- Optionally flags channels stalled with valid high and ready low for too long.
- Sits between the datapath stream interfaces and the board status LEDs.

## Interface
Parameters:
- NUM_CH, 4, number of monitored channels (1..16)
- DIV_WIDTH, 8, width of beat divisor
- HOLDOFF_CYCLES, 1023, minimum idle cycles enforced after each trigger pulse (0 allowed)
- STALL_LIMIT, 1000000, consecutive stall cycles before stall_flag asserts (>=1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_valid  in  NUM_CH  per-channel valid, observed only
- ch_ready  in  NUM_CH  per-channel ready, observed only
- beat_div  in  DIV_WIDTH  beats per trigger, shared by all channels; 0 treated as 1
- clear  in  1  synchronous clear of all counters, pending flags, holdoff and stall state
- trigger_out  out  NUM_CH  registered one-cycle pulse per channel, to blinker `trigger`
- stall_flag  out  NUM_CH  registered level, channel stalled

## Operation
- Beat: ch_valid[i] & ch_ready[i] in a cycle.
- Per-channel beat counter (DIV_WIDTH bits):
  - On a beat, if count >= eff_div-1 (eff_div = max(beat_div,1)), the count resets to 0 and pending[i] is set.
  - Otherwise the count increments.
- beat_div is read live. Lowering it below the current count completes the division on the next beat.
- Per-channel FSM:
  - IDLE: no pending. A pending set goes to FIRE.
  - FIRE: trigger_out[i]=1 for exactly one cycle, pending cleared, holdoff loaded with HOLDOFF_CYCLES. Goes to HOLD, or to IDLE if HOLDOFF_CYCLES=0.
  - HOLD: holdoff counter decrements each cycle. Divisions completing here set pending but do not fire. Multiple completions merge into one pending bit. At holdoff==0, goes to FIRE if pending, else IDLE.
- Stall counter:
  - Increments while ch_valid & ~ch_ready, saturating at STALL_LIMIT.
  - Resets to 0 on any cycle that is not a stall (beat or valid low).
  - stall_flag[i] asserts when the counter reaches STALL_LIMIT and deasserts the cycle after the stall condition ends.
- clear has priority over every update in the same cycle. A beat coincident with clear is discarded.
- Channels are fully independent. No arbitration.

## Timing
- Reset values: trigger_out=0, stall_flag=0, all counters 0, pending=0, FSM=IDLE.
- Reset mid-holdoff or mid-pulse drops the pulse and all pending state immediately.
- Trigger latency: a beat completing a division in cycle t gives trigger_out high in cycle t+1 (state IDLE at t).
- Spacing: consecutive trigger_out rising edges on one channel are at least HOLDOFF_CYCLES+1 cycles apart. With HOLDOFF_CYCLES=0 and eff_div=1, continuous beats give trigger_out high every other cycle (FIRE→IDLE→FIRE).
- A division completing in the same cycle the FSM is in FIRE is captured as pending and fires after the holdoff.
- Stall flag: valid=1, ready=0 starting cycle t gives stall_flag high in cycle t+STALL_LIMIT. It clears one cycle after the first non-stall cycle.
- clear asserted in cycle t: all outputs 0 from cycle t+1.

## Configuration
- ACTIVITY_STALL_DETECT_EN:
  - Defined: stall counters and stall_flag logic are built as described.
  - Undefined: no stall counters are synthesised and stall_flag is tied to 0. Trigger behaviour is unchanged.

## Test plan
- Reset/idle: rst_n low 5 cycles, then idle 100 cycles → trigger_out=0, stall_flag=0 throughout.
- Decimation: beat_div=4, HOLDOFF_CYCLES=0, ch0 beats every cycle for 16 cycles → 4 pulses on trigger_out[0], each one cycle after the 4th/8th/12th/16th beat; other channels 0.
- Holdoff merge: HOLDOFF_CYCLES=10, beat_div=1, ch1 beats continuously 30 cycles → pulses at beat1+1, then every 12 cycles (3 pulses), never closer than 11.
- Divisor edge: beat_div=0 → behaves as 1. Then beat_div changes 8→2 with count=5 → the next beat fires.
- Stall (macro defined, STALL_LIMIT=20): ch2 valid=1, ready=0 for 25 cycles → stall_flag[2] rises at cycle 20, falls one cycle after ready=1. With macro undefined → stays 0.
- Clear/reset mid-operation: assert clear during HOLD with pending set → no pulse afterwards until new beat_div beats. Repeat with rst_n pulse → same result, outputs 0 asynchronously.
